// File: rtl/spi_pkt_pkg.sv
// Shared types, constants and the byte-wise CRC-16/CCITT step for the SPI packet engine.
package spi_pkt_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StRxLen,
    StRxPay,
    StRxCrcH,
    StRxCrcL,
    StCheck,
    StDeliver,
    StTxStatus,
    StTxData,
    StTxCrc
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CRC     = 2'd1,
    ERR_LEN     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

  // Non-reflected, MSB-first byte update.
  function automatic logic [15:0] crc16_update_byte(input logic [15:0] crc,
                                                    input logic [7:0]  data_byte);
    logic [15:0] c;
    c = crc ^ {data_byte, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_word.sv
// Combinational CRC-16 update over the low nbytes bytes of a word, most significant byte first.
module crc16_word import spi_pkt_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned NBYTES    = DATA_WIDTH / 8,
  localparam int unsigned CNT_W     = $clog2(NBYTES + 1)
) (
  input  logic [15:0]           crc_in,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [CNT_W-1:0]      nbytes,
  output logic [15:0]           crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = NBYTES - 1; i >= 0; i--) begin
      if (CNT_W'(i) < nbytes) begin
        crc_out = crc16_update_byte(crc_out, data[8*i +: 8]);
      end
    end
  end

endmodule

// File: rtl/spi_packet_engine.sv
// SPI packet protocol handler: CRC-checked store-and-forward RX to the EKF and framed, CRC'd
// response TX back to the PHY.
module spi_packet_engine import spi_pkt_pkg::*; #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_PAYLOAD    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] CRC_INIT       = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] spi_rx_data,
  input  logic                  spi_rx_valid,
  output logic [DATA_WIDTH-1:0] spi_tx_data,
  output logic                  spi_tx_valid,
  input  logic                  spi_tx_ready,
  output logic [7:0]            cmd,
  output logic [7:0]            payload_length,
  output logic [DATA_WIDTH-1:0] payload_data,
  output logic                  payload_valid,
  input  logic                  payload_ready,
  input  logic [DATA_WIDTH-1:0] response_data,
  input  logic                  response_valid,
  input  logic                  response_last,
  output logic                  response_ready,
  output logic                  pkt_error,
  output logic [1:0]            err_code,
  output logic [15:0]           crc_err_cnt
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);
  localparam int unsigned PTR_W  = $clog2(MAX_PAYLOAD + 1);
  localparam int unsigned IDX_W  = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] ONE_BYTE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ALL_BYTES = CNT_W'(NBYTES);

  state_t           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d, len_q, len_d, word_cnt_q, word_cnt_d;
  logic             len_err_q, len_err_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]      rx_crc_q, rx_crc_d, rcv_crc_q, rcv_crc_d, tx_crc_q, tx_crc_d;
  logic [15:0]      err_cnt_q, err_cnt_d, err_cnt_inc;
  err_code_t        err_q, err_d;
  logic             pkt_error_q, pkt_error_d;
  logic [TO_W-1:0]  idle_q, idle_d;

  logic [DATA_WIDTH-1:0] mem [MAX_PAYLOAD];
  logic                  mem_we;

  logic [15:0]      rx_crc_seed, rx_crc_next, tx_crc_seed, tx_crc_next;
  logic [CNT_W-1:0] rx_nbytes, tx_nbytes;
  logic             rx_active, tx_fire, pay_fire, timed_out;

  // CMD and LENGTH contribute one byte each; payload words contribute all bytes.
  assign rx_crc_seed = (state_q == StIdle) ? CRC_INIT : rx_crc_q;
  assign rx_nbytes   = (state_q == StIdle || state_q == StRxLen) ? ONE_BYTE : ALL_BYTES;

  crc16_word #(.DATA_WIDTH(DATA_WIDTH)) u_rx_crc (
    .crc_in  (rx_crc_seed),
    .data    (spi_rx_data),
    .nbytes  (rx_nbytes),
    .crc_out (rx_crc_next)
  );

  // The status word re-seeds the TX CRC and contributes its low (cmd) byte only.
  assign tx_crc_seed = (state_q == StTxStatus) ? CRC_INIT : tx_crc_q;
  assign tx_nbytes   = (state_q == StTxStatus) ? ONE_BYTE : ALL_BYTES;

  crc16_word #(.DATA_WIDTH(DATA_WIDTH)) u_tx_crc (
    .crc_in  (tx_crc_seed),
    .data    (spi_tx_data),
    .nbytes  (tx_nbytes),
    .crc_out (tx_crc_next)
  );

  assign rx_active = (state_q == StRxLen) || (state_q == StRxPay) ||
                     (state_q == StRxCrcH) || (state_q == StRxCrcL);
  assign timed_out = rx_active && !spi_rx_valid && (idle_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign err_cnt_inc = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;

  assign cmd            = cmd_q;
  assign payload_length = len_q;
  assign pkt_error      = pkt_error_q;
  assign err_code       = err_q;
  assign crc_err_cnt    = err_cnt_q;
  assign payload_valid  = (state_q == StDeliver) && (8'(rd_ptr_q) < len_q);
  assign payload_data   = payload_valid ? mem[rd_ptr_q[IDX_W-1:0]] : '0;
  assign pay_fire       = payload_valid && payload_ready;
  assign tx_fire        = spi_tx_valid && spi_tx_ready;

  always_comb begin
    spi_tx_data    = '0;
    spi_tx_valid   = 1'b0;
    response_ready = 1'b0;
    case (state_q)
      StTxStatus: begin
        spi_tx_data  = DATA_WIDTH'({6'b0, err_q, cmd_q});
        spi_tx_valid = 1'b1;
      end
      StTxData: begin
        spi_tx_data    = response_data;
        spi_tx_valid   = response_valid;
        response_ready = spi_tx_ready;
      end
      StTxCrc: begin
        spi_tx_data  = DATA_WIDTH'(tx_crc_q);
        spi_tx_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    len_err_d   = len_err_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rx_crc_d    = rx_crc_q;
    rcv_crc_d   = rcv_crc_q;
    tx_crc_d    = tx_crc_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    pkt_error_d = 1'b0;
    mem_we      = 1'b0;
    idle_d      = '0;
    if (rx_active) idle_d = spi_rx_valid ? '0 : idle_q + TO_W'(1);

    case (state_q)
      StIdle: begin
        if (spi_rx_valid) begin
          cmd_d      = spi_rx_data[7:0];
          rx_crc_d   = rx_crc_next;
          len_err_d  = 1'b0;
          word_cnt_d = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          state_d    = StRxLen;
        end
      end
      StRxLen: begin
        if (spi_rx_valid) begin
          len_d    = spi_rx_data[7:0];
          rx_crc_d = rx_crc_next;
          if (32'(spi_rx_data[7:0]) > MAX_PAYLOAD) begin
            len_err_d = 1'b1;
            state_d   = StRxPay;
          end else if (spi_rx_data[7:0] == 8'd0) begin
            state_d = StRxCrcH;
          end else begin
            state_d = StRxPay;
          end
        end
      end
      StRxPay: begin
        if (spi_rx_valid) begin
          rx_crc_d   = rx_crc_next;
          word_cnt_d = word_cnt_q + 8'd1;
          if (!len_err_q) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
          if (word_cnt_q == len_q - 8'd1) state_d = StRxCrcH;
        end
      end
      StRxCrcH: begin
        if (spi_rx_valid) begin
          rcv_crc_d[15:8] = spi_rx_data[7:0];
          state_d         = StRxCrcL;
        end
      end
      StRxCrcL: begin
        if (spi_rx_valid) begin
          rcv_crc_d[7:0] = spi_rx_data[7:0];
          state_d        = StCheck;
        end
      end
      StCheck: begin
        if (len_err_q)                  err_d = ERR_LEN;
        else if (rx_crc_q != rcv_crc_q) err_d = ERR_CRC;
        else                            err_d = ERR_NONE;
        if (err_d != ERR_NONE) begin
          pkt_error_d = 1'b1;
          err_cnt_d   = err_cnt_inc;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          state_d     = StTxStatus;
        end else begin
          state_d = StDeliver;
        end
      end
      StDeliver: begin
        if (len_q == 8'd0) begin
          state_d = StTxStatus;
        end else if (pay_fire) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          if (8'(rd_ptr_q) == len_q - 8'd1) state_d = StTxStatus;
        end
      end
      StTxStatus: begin
        if (tx_fire) begin
          tx_crc_d = tx_crc_next;
          state_d  = (err_q != ERR_NONE) ? StTxCrc : StTxData;
        end
      end
      StTxData: begin
        if (tx_fire) begin
          tx_crc_d = tx_crc_next;
          if (response_last) state_d = StTxCrc;
        end
      end
      StTxCrc: begin
        if (tx_fire) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (timed_out) begin
      err_d       = ERR_TIMEOUT;
      pkt_error_d = 1'b1;
      err_cnt_d   = err_cnt_inc;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      idle_d      = '0;
      state_d     = StTxStatus;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cmd_q       <= '0;
      len_q       <= '0;
      word_cnt_q  <= '0;
      len_err_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rx_crc_q    <= CRC_INIT;
      rcv_crc_q   <= '0;
      tx_crc_q    <= CRC_INIT;
      err_q       <= ERR_NONE;
      err_cnt_q   <= '0;
      pkt_error_q <= 1'b0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      len_err_q   <= len_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rx_crc_q    <= rx_crc_d;
      rcv_crc_q   <= rcv_crc_d;
      tx_crc_q    <= tx_crc_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      pkt_error_q <= pkt_error_d;
      idle_q      <= idle_d;
    end
  end

  // Payload storage needs no reset: reads are gated by the per-packet pointers.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q[IDX_W-1:0]] <= spi_rx_data;
  end

endmodule

// File: tb/tb_spi_packet_engine.sv
// Scoreboard bench for spi_packet_engine: stimulus pushes expected beats, monitors pop and compare.
module tb_spi_packet_engine;

  localparam int unsigned DW   = 32;
  localparam int unsigned MAXP = 16;
  localparam int unsigned TO   = 1024;

  logic          clk, rst_n;
  logic [DW-1:0] spi_rx_data, spi_tx_data, payload_data, response_data;
  logic          spi_rx_valid, spi_tx_valid, spi_tx_ready;
  logic [7:0]    cmd, payload_length;
  logic          payload_valid, payload_ready;
  logic          response_valid, response_last, response_ready;
  logic          pkt_error;
  logic [1:0]    err_code;
  logic [15:0]   crc_err_cnt;

  spi_packet_engine #(
    .DATA_WIDTH     (DW),
    .MAX_PAYLOAD    (MAXP),
    .TIMEOUT_CYCLES (TO),
    .CRC_INIT       (16'hFFFF)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .spi_rx_data    (spi_rx_data),
    .spi_rx_valid   (spi_rx_valid),
    .spi_tx_data    (spi_tx_data),
    .spi_tx_valid   (spi_tx_valid),
    .spi_tx_ready   (spi_tx_ready),
    .cmd            (cmd),
    .payload_length (payload_length),
    .payload_data   (payload_data),
    .payload_valid  (payload_valid),
    .payload_ready  (payload_ready),
    .response_data  (response_data),
    .response_valid (response_valid),
    .response_last  (response_last),
    .response_ready (response_ready),
    .pkt_error      (pkt_error),
    .err_code       (err_code),
    .crc_err_cnt    (crc_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    cmd;
    logic [7:0]    len;
    logic [DW-1:0] data;
  } pay_t;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  pay_t          exp_pay[$];
  logic [DW-1:0] exp_tx[$];
  logic [17:0]   exp_err[$];
  logic [DW-1:0] resp_q[$];
  logic [DW-1:0] w_q[$];
  logic [DW-1:0] r_q[$];
  logic          bp_en = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Bit-serial reference CRC-16/CCITT (poly 0x1021, no reflection).
  function automatic logic [15:0] m_crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ b[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  function automatic logic [15:0] m_crc_word(input logic [15:0] c, input logic [DW-1:0] w);
    for (int i = DW / 8 - 1; i >= 0; i--) c = m_crc_byte(c, w[8*i +: 8]);
    return c;
  endfunction

  // ---------------- monitors ----------------
  pay_t          p;
  logic [DW-1:0] t;
  logic [17:0]   e;
  logic          pay_stall = 1'b0, tx_stall = 1'b0;
  logic [DW-1:0] pay_held, tx_held;

  always @(negedge clk) begin
    if (!rst_n) begin
      pay_stall = 1'b0;
      tx_stall  = 1'b0;
    end else begin
      if (pay_stall) begin
        chk("payload_hold_valid", payload_valid, 1);
        chk("payload_hold_data", payload_data, pay_held);
      end
      pay_stall = payload_valid && !payload_ready;
      pay_held  = payload_data;
      if (payload_valid && payload_ready) begin
        if (exp_pay.size() == 0) begin
          chk("payload_unexpected", payload_valid, 0);
        end else begin
          p = exp_pay.pop_front();
          chk("payload_data", payload_data, p.data);
          chk("payload_cmd", cmd, p.cmd);
          chk("payload_length", payload_length, p.len);
          chk("payload_err_code", err_code, 0);
        end
      end

      if (tx_stall) begin
        chk("tx_hold_valid", spi_tx_valid, 1);
        chk("tx_hold_data", spi_tx_data, tx_held);
      end
      tx_stall = spi_tx_valid && !spi_tx_ready;
      tx_held  = spi_tx_data;
      if (spi_tx_valid && spi_tx_ready) begin
        if (exp_tx.size() == 0) begin
          chk("tx_unexpected", spi_tx_valid, 0);
        end else begin
          t = exp_tx.pop_front();
          chk("tx_word", spi_tx_data, t);
        end
      end

      if (pkt_error) begin
        if (exp_err.size() == 0) begin
          chk("pkt_error_unexpected", pkt_error, 0);
        end else begin
          e = exp_err.pop_front();
          chk("err_code", err_code, e[17:16]);
          chk("crc_err_cnt", crc_err_cnt, e[15:0]);
        end
      end
    end
  end

  // ---------------- response source and backpressure ----------------
  logic resp_fire;
  initial begin
    response_valid = 1'b0;
    response_data  = '0;
    response_last  = 1'b0;
    forever begin
      @(negedge clk);
      resp_fire = response_valid && response_ready;
      @(posedge clk);
      #1;
      if (resp_fire && resp_q.size() > 0) void'(resp_q.pop_front());
      response_valid = (resp_q.size() > 0);
      response_data  = (resp_q.size() > 0) ? resp_q[0] : '0;
      response_last  = (resp_q.size() == 1);
    end
  end

  initial begin
    payload_ready = 1'b1;
    spi_tx_ready  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      payload_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      spi_tx_ready  = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic rx_word(input logic [DW-1:0] w);
    @(posedge clk);
    #1;
    spi_rx_data  = w;
    spi_rx_valid = 1'b1;
    @(posedge clk);
    #1;
    spi_rx_valid = 1'b0;
    spi_rx_data  = '0;
  endtask

  // Expected traffic for one packet; w_q holds the payload, r_q the EKF response.
  task automatic expect_pkt(input logic [7:0] c, input logic [7:0] len, input logic [1:0] code);
    logic [15:0] tc;
    tc = m_crc_byte(16'hFFFF, c);
    if (code == 2'd0) begin
      foreach (w_q[i]) exp_pay.push_back('{cmd: c, len: len, data: w_q[i]});
      exp_tx.push_back(DW'(c));
      foreach (r_q[i]) begin
        exp_tx.push_back(r_q[i]);
        tc = m_crc_word(tc, r_q[i]);
        resp_q.push_back(r_q[i]);
      end
    end else begin
      exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 1;
      exp_err.push_back({code, 16'(exp_cnt)});
      exp_tx.push_back(DW'({6'b0, code, c}));
    end
    exp_tx.push_back(DW'(tc));
  endtask

  task automatic send_pkt(input logic [7:0] c, input logic [7:0] len, input logic [7:0] flip);
    logic [15:0] rc;
    rc = m_crc_byte(m_crc_byte(16'hFFFF, c), len);
    foreach (w_q[i]) rc = m_crc_word(rc, w_q[i]);
    rx_word(DW'(c));
    rx_word(DW'(len));
    foreach (w_q[i]) rx_word(w_q[i]);
    rx_word(DW'(rc[15:8]));
    rx_word(DW'(rc[7:0] ^ flip));
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_pay.size() != 0 || exp_err.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_drain_tx"}, exp_tx.size(), 0);
    chk({name, "_drain_pay"}, exp_pay.size(), 0);
    exp_tx.delete();
    exp_pay.delete();
    exp_err.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({name, "_idle_tx_valid"}, spi_tx_valid, 0);
    chk({name, "_idle_pay_valid"}, payload_valid, 0);
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, "_tx_valid"}, spi_tx_valid, 0);
    chk({name, "_tx_data"}, spi_tx_data, 0);
    chk({name, "_pay_valid"}, payload_valid, 0);
    chk({name, "_pay_data"}, payload_data, 0);
    chk({name, "_cmd"}, cmd, 0);
    chk({name, "_len"}, payload_length, 0);
    chk({name, "_resp_ready"}, response_ready, 0);
    chk({name, "_pkt_error"}, pkt_error, 0);
    chk({name, "_err_code"}, err_code, 0);
    chk({name, "_err_cnt"}, crc_err_cnt, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    string       s;
    logic [15:0] g;
    rst_n        = 1'b0;
    spi_rx_data  = '0;
    spi_rx_valid = 1'b0;

    s = "123456789";
    g = 16'hFFFF;
    for (int i = 0; i < s.len(); i++) g = spi_pkt_pkg::crc16_update_byte(g, s[i]);
    chk("golden_crc_123456789", g, 16'h29B1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Valid packet.
    w_q = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
    r_q = '{32'hCAFEF00D, 32'h12345678};
    expect_pkt(8'h05, 8'd3, 2'd0);
    send_pkt(8'h05, 8'd3, 8'h00);
    drain("valid", 200);

    // Same packet, CRC_L corrupted.
    expect_pkt(8'h05, 8'd3, 2'd1);
    send_pkt(8'h05, 8'd3, 8'h01);
    drain("badcrc", 200);

    // Oversize length, then a clean packet.
    w_q.delete();
    for (int i = 0; i < 17; i++) w_q.push_back(32'hA5000000 + i);
    expect_pkt(8'h21, 8'd17, 2'd2);
    send_pkt(8'h21, 8'd17, 8'h00);
    drain("oversize", 200);
    w_q = '{32'h11112222, 32'h33334444};
    r_q = '{32'h0BADC0DE};
    expect_pkt(8'h22, 8'd2, 2'd0);
    send_pkt(8'h22, 8'd2, 8'h00);
    drain("after_oversize", 200);

    // Inter-word timeout after 2 of 4 payload words.
    expect_pkt(8'h07, 8'd4, 2'd3);
    rx_word(DW'(8'h07));
    rx_word(DW'(8'd4));
    rx_word(32'h55550001);
    rx_word(32'h55550002);
    drain("timeout", TO + 300);

    // Random backpressure on payload and TX.
    bp_en = 1'b1;
    w_q = '{32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'hD0E0F001};
    r_q = '{32'hFEEDFACE, 32'h0000FFFF, 32'h80000001};
    expect_pkt(8'h33, 8'd4, 2'd0);
    send_pkt(8'h33, 8'd4, 8'h00);
    drain("backpressure", 600);
    bp_en = 1'b0;

    // Zero length.
    w_q.delete();
    r_q = '{32'h76543210};
    expect_pkt(8'h0A, 8'd0, 2'd0);
    send_pkt(8'h0A, 8'd0, 8'h00);
    drain("zero_len", 200);

    // Reset mid-payload, then a clean packet.
    rx_word(DW'(8'h0B));
    rx_word(DW'(8'd4));
    rx_word(32'h77770001);
    rx_word(32'h77770002);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    exp_cnt = 0;
    resp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    w_q = '{32'hABCD0123};
    r_q = '{32'h5A5A5A5A, 32'hA5A5A5A5};
    expect_pkt(8'h0C, 8'd1, 2'd0);
    send_pkt(8'h0C, 8'd1, 8'h00);
    drain("after_reset", 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
